multi_sum_pipe: RTL
===================

Name: multi_sum_pipe

Overview:
- Parametrised, handshaked successor of the fixed three-operand 16-bit registered adder.
- Sums NUM_IN unsigned operands per beat through a 2-stage pipeline.
- Either emits each beat's sum, or accumulates beats across a frame and emits once on the last beat.
- Sits between operand producers and the final result consumer; valid/ready backpressure on both sides.

Parameters:
- DATA_W, 16, width of each unsigned input operand.
- NUM_IN, 3, number of operands per beat (>=2).
- OUT_W, 16, width of the result port.
- ACC_W, 24, accumulator width (>= DATA_W+clog2(NUM_IN)).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_data  in  NUM_IN*DATA_W  operands; operand k at bits [k*DATA_W +: DATA_W].
- in_valid  in  1  beat present.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_mode  in  1  0 = single-beat sum; 1 = accumulate across a frame.
- in_last  in  1  final beat of an accumulate frame; ignored when in_mode=0.
- out_data  out  OUT_W  result.
- out_ovf  out  1  result exceeded OUT_W range (or accumulator carried out).
- out_valid  out  1  result present.
- out_ready  in  1  result consumed when out_valid & out_ready.

Behaviour:
- Reset (rst_n=0 at edge): out_data=0, out_ovf=0, out_valid=0, stage-1 valid=0, accumulator=0, frame-open flag=0, sticky carry=0. Reset mid-frame discards the partial frame.
- advance = ~out_valid | out_ready; in_ready = advance (combinational, also 1 during reset). Whole pipe holds when advance=0; bubbles propagate.
- Stage 1, on advance:
  - Registers s1_sum = sum of all NUM_IN operands at width SUM_W = DATA_W+clog2(NUM_IN); no loss.
  - Registers s1_valid = in_valid, plus mode and last.
- Stage 2, on advance with s1_valid=1:
  - mode 0: result = s1_sum zero-extended; out_valid=1. Accumulator and frame state untouched, including mid-frame, so a mode-0 beat may be interleaved inside an open frame.
  - mode 1: acc_next = (frame_open ? acc : 0) + s1_sum, computed in ACC_W+1 bits. A carry out of ACC_W sets the sticky carry; acc keeps the low ACC_W bits (wraps).
    - in_last=0: acc <= acc_next; frame_open <= 1; no output.
    - in_last=1: result = acc_next low ACC_W bits; out_valid=1; acc <= 0; frame_open <= 0; sticky carry cleared after reporting. A single-beat frame (first beat with last=1) is legal.
- Stage 2, on advance with s1_valid=0: out_valid <= 0.
- Output narrowing: ovf = (result >= 2^OUT_W) | sticky carry (mode 1). out_data = result[OUT_W-1:0] unless the optional feature is enabled. out_ovf is registered with out_data.
- Latency: accepted beat to out_valid is 2 cycles when unstalled. Throughput is 1 beat/cycle.
- Stalled output: out_data, out_ovf and out_valid are held stable until consumed.
- in_data is not required stable once a beat is accepted.

Optional Feature:
- Macro: MULTI_SUM_SAT_EN.
- Defined: when ovf=1, out_data = 2^OUT_W-1 (all ones) instead of the truncated value.
- Undefined: out_data is always the low OUT_W bits of the result (modulo wrap).
- out_ovf behaves identically in both builds.

Test Plan:
- Single sums: defaults, mode 0, operands {1,2,3} then {0x1000,0x2000,0x0300} back-to-back -> out_data 6 then 0x3300, each 2 cycles after acceptance, out_ovf=0.
- Overflow: mode 0, {0xFFFF,0xFFFF,0x0003} -> result 0x20001, out_ovf=1; out_data=0x0001 without MULTI_SUM_SAT_EN, 0xFFFF with it.
- Accumulate frame: mode 1 beats {1,1,1},{2,2,2},{3,3,3 last} -> exactly one output, out_data=18. Next frame {5,0,0 last} -> 5 (accumulator restarted).
- Backpressure: hold out_ready=0 with 3 beats offered -> in_ready falls once out_valid=1; out_data is held stable; no beat lost or duplicated; outputs appear in order after release.
- Interleave: open mode-1 frame with {10,0,0}; mode-0 beat {4,4,4}; mode-1 beat {1,0,0 last} -> outputs 12 then 11.
- Reset mid-frame: after mode-1 beat {7,0,0}, pulse rst_n=0 for 1 cycle, then mode-1 beat {2,0,0 last} -> outputs all 0 during reset, then out_data=2.

Source files
------------

// File: rtl/multi_sum_pipe_if.sv
// Stream bundle for multi_sum_pipe: operand beats in, narrowed sums out.
// master = producer/consumer side, slave = the summing pipeline.
interface multi_sum_pipe_if #(
    parameter int DATA_W = 16,
    parameter int NUM_IN = 3,
    parameter int OUT_W  = 16
);
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_mode;
    logic                     in_last;
    logic [OUT_W-1:0]         out_data;
    logic                     out_ovf;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, in_mode, in_last, out_ready,
        input  in_ready, out_data, out_ovf, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_mode, in_last, out_ready,
        output in_ready, out_data, out_ovf, out_valid
    );
endinterface

// File: rtl/multi_sum_pipe.sv
// Two-stage NUM_IN-operand adder with per-beat or per-frame (accumulated) results.
// Optional MULTI_SUM_SAT_EN: overflowing results saturate to all ones instead of wrapping.
module multi_sum_pipe #(
    parameter int DATA_W = 16,
    parameter int NUM_IN = 3,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    multi_sum_pipe_if.slave   bus
);
    localparam int SUM_W = DATA_W + $clog2(NUM_IN);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OPEN = 1'b1
    } frame_state_e;

    logic                advance;
    logic [DATA_W-1:0]   opnd [NUM_IN];
    logic [SUM_W-1:0]    sum_d;

    logic                s1_valid_q;
    logic [SUM_W-1:0]    s1_sum_q;
    logic                s1_mode_q;
    logic                s1_last_q;

    frame_state_e        state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                sticky_q, sticky_d;
    logic                frame_open;
    logic [ACC_W:0]      acc_sum;
    logic                carry_any;

    logic                emit;
    logic [ACC_W-1:0]    res;
    logic                res_carry;
    logic                res_hi_nz;
    logic [OUT_W-1:0]    res_lo;
    logic                res_ovf;
    logic [OUT_W-1:0]    res_out;

    logic                out_valid_q, out_valid_d;
    logic [OUT_W-1:0]    out_data_q, out_data_d;
    logic                out_ovf_q, out_ovf_d;

    // The whole pipe moves together; a held output freezes both stages.
    assign advance      = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = advance;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_opnd
            assign opnd[gi] = bus.in_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sum_d = sum_d + SUM_W'(opnd[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_mode_q  <= 1'b0;
            s1_last_q  <= 1'b0;
        end else if (advance) begin
            s1_valid_q <= bus.in_valid;
            s1_sum_q   <= sum_d;
            s1_mode_q  <= bus.in_mode;
            s1_last_q  <= bus.in_last;
        end
    end

    assign frame_open = (state_q == ST_OPEN);
    assign acc_sum    = {1'b0, (frame_open ? acc_q : {ACC_W{1'b0}})} + (ACC_W+1)'(s1_sum_q);
    assign carry_any  = (frame_open & sticky_q) | acc_sum[ACC_W];

    // Frame FSM and result selection; mode-0 beats leave frame state alone.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        emit      = 1'b0;
        res       = '0;
        res_carry = 1'b0;
        if (advance && s1_valid_q) begin
            if (!s1_mode_q) begin
                emit = 1'b1;
                res  = ACC_W'(s1_sum_q);
            end else if (s1_last_q) begin
                emit      = 1'b1;
                res       = acc_sum[ACC_W-1:0];
                res_carry = carry_any;
                acc_d     = '0;
                sticky_d  = 1'b0;
                state_d   = ST_IDLE;
            end else begin
                acc_d    = acc_sum[ACC_W-1:0];
                sticky_d = carry_any;
                state_d  = ST_OPEN;
            end
        end
    end

    generate
        if (ACC_W > OUT_W) begin : g_narrow
            assign res_hi_nz = |res[ACC_W-1:OUT_W];
            assign res_lo    = res[OUT_W-1:0];
        end else begin : g_wide
            assign res_hi_nz = 1'b0;
            assign res_lo    = OUT_W'(res);
        end
    endgenerate

    assign res_ovf = res_hi_nz | res_carry;

`ifdef MULTI_SUM_SAT_EN
    assign res_out = res_ovf ? {OUT_W{1'b1}} : res_lo;
`else
    assign res_out = res_lo;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (advance) begin
            out_valid_d = emit;
            if (emit) begin
                out_data_d = res_out;
                out_ovf_d  = res_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule
